// File: rtl/fir_window_sequencer.sv
// Sample-queue controller: decimated RAM writes, fill tracking, and window read bursts for the FIR MAC.
// Optional build macro FIR_SEQ_OVERRUN_EN adds a sticky overrun flag for merged (lost) bursts.
module fir_window_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int WIN_LEN = 1021,
  parameter int DECIM   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt_smpl,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic              sequencing,
  output logic              rd_vld,
  output logic [ADDR_W-1:0] coef_idx,
  output logic              first_smpl,
  output logic              last_smpl,
  output logic              full
`ifdef FIR_SEQ_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  // state | meaning
  // FILL  | queue not yet holding WIN_LEN samples
  // IDLE  | window available, waiting for a new accepted sample (or pending burst)
  // SEQ   | issuing WIN_LEN read addresses, oldest sample first

  localparam int                DEC_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DEC_W-1:0]  DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [ADDR_W-1:0] WIN      = ADDR_W'(WIN_LEN);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(WIN_LEN - 1);

  typedef enum logic [1:0] {FILL, IDLE, SEQ} state_t;

  state_t             state, state_nxt;
  logic [DEC_W-1:0]   dec_cnt;
  logic [ADDR_W-1:0]  wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0]  fill_cnt, fill_nxt;
  logic [ADDR_W-1:0]  idx;
  logic               pending;
  logic               accepted;
  logic               enter_seq;
  logic               burst_done;

  assign accepted   = wrt_smpl && (dec_cnt == DEC_LAST);
  assign we         = accepted;
  assign waddr      = wr_ptr;
  assign wr_ptr_nxt = accepted ? wr_ptr + ADDR_W'(1) : wr_ptr;
  assign fill_nxt   = (accepted && (fill_cnt != WIN)) ? fill_cnt + ADDR_W'(1) : fill_cnt;
  assign burst_done = (state == SEQ) && (idx == IDX_LAST);

  always_comb begin
    state_nxt = state;
    enter_seq = 1'b0;
    unique case (state)
      FILL: begin
        if (accepted && (fill_cnt == IDX_LAST)) begin
          state_nxt = SEQ;
          enter_seq = 1'b1;
        end
      end
      IDLE: begin
        if (accepted || pending) begin
          state_nxt = SEQ;
          enter_seq = 1'b1;
        end
      end
      SEQ: begin
        if (burst_done) state_nxt = IDLE;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt    <= '0;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      full       <= 1'b0;
      raddr      <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      sequencing <= 1'b0;
      rd_vld     <= 1'b0;
      coef_idx   <= '0;
      first_smpl <= 1'b0;
      last_smpl  <= 1'b0;
    end else begin
      if (wrt_smpl) dec_cnt <= accepted ? '0 : dec_cnt + DEC_W'(1);
      wr_ptr   <= wr_ptr_nxt;
      fill_cnt <= fill_nxt;
      full     <= (fill_nxt == WIN);

      // base uses the post-increment pointer so a write on the launch cycle joins this window
      if (enter_seq) begin
        raddr   <= wr_ptr_nxt - WIN;
        idx     <= '0;
        pending <= 1'b0;
      end else begin
        if ((state == SEQ) && !burst_done) begin
          raddr <= raddr + ADDR_W'(1);
          idx   <= idx + ADDR_W'(1);
        end
        if (accepted && (state == SEQ)) pending <= 1'b1;
      end

      sequencing <= (state_nxt == SEQ);
      rd_vld     <= sequencing;
      coef_idx   <= sequencing ? idx : '0;
      first_smpl <= sequencing && (idx == '0);
      last_smpl  <= sequencing && (idx == IDX_LAST);
    end
  end

`ifdef FIR_SEQ_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   overrun <= 1'b0;
    else if (accepted && pending) overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fir_window_sequencer.sv
// Scoreboard bench for fir_window_sequencer: expected writes and bursts are queued by stimulus, checked by a monitor.
module tb_fir_window_sequencer;
  localparam int ADDR_W  = 10;
  localparam int WIN_LEN = 1021;
  localparam int DECIM   = 2;

  typedef struct {
    logic [ADDR_W-1:0] base;
    bit                b2b;
  } burst_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wrt_smpl = 1'b0;
  logic              we, sequencing, rd_vld, first_smpl, last_smpl, full;
  logic [ADDR_W-1:0] waddr, raddr, coef_idx;
`ifdef FIR_SEQ_OVERRUN_EN
  logic              overrun;
`endif

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_w[$];
  burst_t            exp_b[$];
  int                dec_m = 0;
  logic [ADDR_W-1:0] wp_m = '0;

  always #5 clk = ~clk;

  fir_window_sequencer #(.ADDR_W(ADDR_W), .WIN_LEN(WIN_LEN), .DECIM(DECIM)) dut (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt_smpl), .we(we), .waddr(waddr), .raddr(raddr),
    .sequencing(sequencing), .rd_vld(rd_vld), .coef_idx(coef_idx), .first_smpl(first_smpl),
    .last_smpl(last_smpl), .full(full)
`ifdef FIR_SEQ_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic pulse_on();
    @(posedge clk);
    #1 wrt_smpl = 1'b1;
    if (dec_m == DECIM - 1) begin
      dec_m = 0;
      exp_w.push_back(wp_m);
      wp_m = wp_m + 1'b1;
    end else begin
      dec_m++;
    end
  endtask

  task automatic pulse_off();
    @(posedge clk);
    #1 wrt_smpl = 1'b0;
  endtask

  task automatic spaced(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      pulse_on();
      pulse_off();
      repeat (gap - 2) @(posedge clk);
    end
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) pulse_on();
    pulse_off();
  endtask

  task automatic push_burst(input logic [ADDR_W-1:0] base, input bit b2b);
    burst_t b;
    b.base = base;
    b.b2b  = b2b;
    exp_b.push_back(b);
  endtask

  task automatic wait_seq(input logic lvl, input int budget, input string name);
    int n = 0;
    while (sequencing !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(sequencing === lvl), 1);
  endtask

  // monitor
  bit                in_burst = 0;
  bit                prev_seq = 0;
  int                k = 0, idle_cnt = 0, b_err = 0, bad_k = 0, rd_bad = 0, rd_bad_start = 0;
  logic [ADDR_W-1:0] prev_k = '0, bad_addr = '0;
  burst_t            cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_burst = 0;
      prev_seq = 0;
      idle_cnt = 0;
    end else begin
      if (we) begin
        if (exp_w.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected write: waddr=%0d, expected no write", waddr);
        end else begin
          chk("waddr", 32'(waddr), 32'(exp_w.pop_front()));
        end
        if (sequencing) chk("read/write collision", 32'(raddr == waddr), 0);
      end

      if ((prev_seq || rd_vld) &&
          (rd_vld !== prev_seq || coef_idx !== prev_k ||
           first_smpl !== (prev_seq && prev_k == 0) ||
           last_smpl !== (prev_seq && prev_k == ADDR_W'(WIN_LEN - 1)))) begin
        rd_bad++;
        if (rd_bad < 4)
          $display("  rd stream off: rd_vld=%b coef_idx=%0d first=%b last=%b, want idx %0d", rd_vld, coef_idx,
                   first_smpl, last_smpl, prev_k);
      end

      if (sequencing) begin
        if (!in_burst) begin
          in_burst = 1;
          k = 0;
          b_err = 0;
          rd_bad_start = rd_bad;
          if (exp_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected burst: raddr=%0d, expected no burst", raddr);
            cur.base = raddr;
            cur.b2b  = 0;
          end else begin
            cur = exp_b.pop_front();
            if (cur.b2b) chk("idle gap before follow-on burst", 32'(idle_cnt), 1);
          end
        end
        if (raddr !== cur.base + ADDR_W'(k)) begin
          if (b_err == 0) begin
            bad_k = k;
            bad_addr = raddr;
          end
          b_err++;
        end
        prev_k = ADDR_W'(k);
        k++;
        prev_seq = 1;
      end else begin
        if (in_burst) begin
          in_burst = 0;
          chk("burst length", 32'(k), 32'(WIN_LEN));
          checks++;
          if (b_err != 0) begin
            errors++;
            $display("FAIL burst raddr (base %0d): got %0d at idx %0d, expected %0d", cur.base, bad_addr, bad_k,
                     cur.base + ADDR_W'(bad_k));
          end
          chk("burst rd_vld/coef alignment", 32'(rd_bad - rd_bad_start), 0);
          idle_cnt = 1;
        end else begin
          idle_cnt++;
        end
        prev_seq = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset addresses", {2'b0, waddr, raddr, coef_idx}, 0);
    chk("reset flags", {26'b0, we, sequencing, rd_vld, first_smpl, last_smpl, full}, 0);
`ifdef FIR_SEQ_OVERRUN_EN
    chk("reset overrun", 32'(overrun), 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    // fill: 1021 accepted writes at waddr 0..1020, first burst base 0
    push_burst(10'd0, 0);
    spaced(2041, 4);
    pulse_on();
    @(negedge clk);
    chk("full before last fill write", 32'(full), 0);
    chk("sequencing before last fill write", 32'(sequencing), 0);
    pulse_off();
    @(negedge clk);
    chk("full after last fill write", 32'(full), 1);
    chk("sequencing after last fill write", 32'(sequencing), 1);
    chk("first raddr of fill burst", 32'(raddr), 0);
    wait_seq(1'b0, 1100, "fill burst ends");

    // steady state: odd pulse writes nothing, even pulse writes 1021 and launches base 1
    pulse_on();
    pulse_off();
    repeat (2) @(posedge clk);
    push_burst(10'd1, 0);
    pulse_on();
    pulse_off();
    @(negedge clk);
    chk("sequencing cycle after write", 32'(sequencing), 1);
    chk("steady burst first raddr", 32'(raddr), 1);

    // back-to-back: one write (1022) mid-burst -> one idle cycle, base 2
    repeat (500) @(posedge clk);
    push_burst(10'd2, 1);
    stream(2);
    wait_seq(1'b0, 1100, "burst base 1 ends");
    wait_seq(1'b1, 5, "follow-on burst base 2 starts");

    // two writes (1023, then wrap to 0) in one burst -> merged, base 4
    repeat (300) @(posedge clk);
    push_burst(10'd4, 1);
    stream(2);
    @(negedge clk);
`ifdef FIR_SEQ_OVERRUN_EN
    chk("overrun after first write", 32'(overrun), 0);
`endif
    stream(2);
    @(negedge clk);
`ifdef FIR_SEQ_OVERRUN_EN
    chk("overrun after second write", 32'(overrun), 1);
`endif
    wait_seq(1'b0, 1100, "burst base 2 ends");
    wait_seq(1'b1, 5, "merged burst base 4 starts");
    wait_seq(1'b0, 1100, "merged burst ends");
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (sequencing) seen++;
      end
      chk("no second follow-on burst", 32'(seen), 0);
    end

    // wrap: advance write pointer to 1017 so the last burst reads 1020..1023, 0..1016
    push_burst(10'd5, 0);
    stream(2);
    wait_seq(1'b1, 5, "burst base 5 starts");
    push_burst(10'd405, 1);
    stream(800);
    wait_seq(1'b0, 1100, "burst base 5 ends");
    wait_seq(1'b1, 5, "burst base 405 starts");
    push_burst(10'd805, 1);
    stream(800);
    wait_seq(1'b0, 1100, "burst base 405 ends");
    wait_seq(1'b1, 5, "burst base 805 starts");
    push_burst(10'd1020, 1);
    stream(430);
    wait_seq(1'b0, 1100, "burst base 805 ends");
    wait_seq(1'b1, 5, "wrapping burst starts");
    chk("wrapping burst first raddr", 32'(raddr), 1020);
    wait_seq(1'b0, 1100, "wrapping burst ends");
`ifdef FIR_SEQ_OVERRUN_EN
    chk("overrun sticky", 32'(overrun), 1);
`endif

    // reset in the middle of a burst
    push_burst(10'd1021, 0);
    stream(2);
    wait_seq(1'b1, 5, "burst before reset starts");
    repeat (501) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-burst reset addresses", {2'b0, waddr, raddr, coef_idx}, 0);
    chk("mid-burst reset flags", {26'b0, we, sequencing, rd_vld, first_smpl, last_smpl, full}, 0);
`ifdef FIR_SEQ_OVERRUN_EN
    chk("mid-burst reset overrun", 32'(overrun), 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dec_m = 0;
    wp_m  = '0;
    stream(2);
    @(negedge clk);
    chk("full after refill write", 32'(full), 0);
    chk("no burst after refill write", 32'(sequencing), 0);

    repeat (5) @(posedge clk);
    chk("write queue drained", 32'(exp_w.size()), 0);
    chk("burst queue drained", 32'(exp_b.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
